// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: width codes, FSM states,
// error causes and the store-forwarding entry layout.
package dmem_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned WADDR_W = 30;
  localparam int unsigned STRB_W  = 4;

  typedef enum logic [1:0] {
    W_BYTE = 2'b00,
    W_HALF = 2'b01,
    W_WORD = 2'b10,
    W_RSVD = 2'b11
  } width_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_RESP = 2'b10,
    S_DONE = 2'b11
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_RANGE   = 3'd1,
    ERR_WIDTH   = 3'd2,
    ERR_ALIGN   = 3'd3,
    ERR_TIMEOUT = 3'd4
  } err_cause_e;

  // Last-store entry used when store-to-load forwarding is built in
  typedef struct packed {
    logic [WADDR_W-1:0] addr;
    logic [STRB_W-1:0]  strb;
    logic [XLEN-1:0]    data;
  } fwd_ent_t;

  // Half needs an even address, word needs a 4-byte aligned address
  function automatic logic is_misaligned(input logic [1:0] a_lo, input width_e w);
    logic bad;
    bad = 1'b0;
    if (w == W_HALF && a_lo[0]) bad = 1'b1;
    if (w == W_WORD && a_lo != 2'b00) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane helper: store strobes, store-data replication and load
// lane extraction with sign/zero extension. Purely combinational.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]        a_lo,
  input  width_e            width,
  input  logic              ext,
  input  logic [XLEN-1:0]   st_data,
  input  logic [XLEN-1:0]   ld_word,
  output logic [STRB_W-1:0] strb_c,
  output logic [XLEN-1:0]   wdata_c,
  output logic [XLEN-1:0]   ldata_c
);

  logic [XLEN-1:0] shifted_c;
  logic [7:0]      byte_c;
  logic [15:0]     half_c;

  // Lane steering for both the store and the load direction
  always_comb begin
    strb_c    = '0;
    wdata_c   = st_data;
    ldata_c   = ld_word;
    shifted_c = ld_word >> {a_lo, 3'b000};
    byte_c    = shifted_c[7:0];
    half_c    = a_lo[1] ? ld_word[31:16] : ld_word[15:0];
    case (width)
      W_BYTE: begin
        strb_c  = 4'b0001 << a_lo;
        wdata_c = {4{st_data[7:0]}};
        ldata_c = ext ? {24'h000000, byte_c} : {{24{byte_c[7]}}, byte_c};
      end
      W_HALF: begin
        strb_c  = 4'b0011 << {a_lo[1], 1'b0};
        wdata_c = {2{st_data[15:0]}};
        ldata_c = ext ? {16'h0000, half_c} : {{16{half_c[15]}}, half_c};
      end
      W_WORD: begin
        strb_c  = 4'b1111;
        wdata_c = st_data;
        ldata_c = ld_word;
      end
      default: begin
        strb_c  = '0;
        wdata_c = st_data;
        ldata_c = ld_word;
      end
    endcase
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: turns core load/store requests into single word
// transactions on a grant/rvalid bus, with window/alignment checks and a
// wait timeout. Optional build macro DMEM_STORE_FWD_EN adds a one-entry
// last-store register that serves fully covered loads without the bus.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int unsigned SIZE_LOG2 = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               r_ena,
  input  logic               w_ena,
  input  logic [31:0]        addr,
  input  logic [1:0]         width,
  input  logic               ext,
  input  logic [XLEN-1:0]    data_in,
  output logic               ready,
  output logic               valid,
  output logic               err,
  output logic [XLEN-1:0]    data_out,
  output logic               mem_req,
  output logic               mem_we,
  output logic [WADDR_W-1:0] mem_addr,
  output logic [STRB_W-1:0]  mem_wstrb,
  output logic [XLEN-1:0]    mem_wdata,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [XLEN-1:0]    mem_rdata
);

  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

  state_e            state;
  logic [1:0]        lo_q;
  width_e            width_q;
  logic              ext_q;
  logic [TCNT_W-1:0] tcnt;

  err_cause_e        cause_c;
  logic [31:0]       off_c;
  logic              tmo_c;
  logic              fwd_hit_c;
  logic              sel_live_c;
  logic [1:0]        lane_lo_c;
  width_e            lane_w_c;
  logic              lane_ext_c;
  logic [XLEN-1:0]   lane_ld_c;
  logic [STRB_W-1:0] strb_c;
  logic [XLEN-1:0]   wdata_c;
  logic [XLEN-1:0]   ldata_c;

  // Request checks on the live inputs; wrap-around makes below-base addresses fail too
  always_comb begin
    cause_c = ERR_NONE;
    off_c   = addr - BASE_ADDR;
    if ((off_c >> SIZE_LOG2) != 32'd0)         cause_c = ERR_RANGE;
    else if (width_e'(width) == W_RSVD)        cause_c = ERR_WIDTH;
    else if (is_misaligned(addr[1:0], width_e'(width))) cause_c = ERR_ALIGN;
  end

  // Waiting cycle that would reach the timeout limit
  assign tmo_c = (32'(tcnt) + 32'd1) >= 32'(TIMEOUT);

  // Lane helper sees the live request in IDLE and the captured one afterwards
  assign sel_live_c = (state == S_IDLE);
  assign lane_lo_c  = sel_live_c ? addr[1:0] : lo_q;
  assign lane_w_c   = sel_live_c ? width_e'(width) : width_q;
  assign lane_ext_c = sel_live_c ? ext : ext_q;

  dmem_lane u_lane (
    .a_lo    (lane_lo_c),
    .width   (lane_w_c),
    .ext     (lane_ext_c),
    .st_data (data_in),
    .ld_word (lane_ld_c),
    .strb_c  (strb_c),
    .wdata_c (wdata_c),
    .ldata_c (ldata_c)
  );

`ifdef DMEM_STORE_FWD_EN
  fwd_ent_t fwd_q;
  logic     fwd_vld;
  logic     fwd_same_c;

  // Load hits when the same word holds every byte it needs
  assign fwd_hit_c  = fwd_vld && !w_ena && (cause_c == ERR_NONE) &&
                      (fwd_q.addr == addr[31:2]) && ((strb_c & ~fwd_q.strb) == 4'b0000);
  assign lane_ld_c  = sel_live_c ? fwd_q.data : mem_rdata;
  assign fwd_same_c = fwd_vld && (fwd_q.addr == mem_addr);

  // Capture each granted store, merging bytes when it hits the held word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_vld <= 1'b0;
      fwd_q   <= '0;
    end else if (state == S_REQ && mem_gnt && mem_we) begin
      fwd_vld    <= 1'b1;
      fwd_q.addr <= mem_addr;
      fwd_q.strb <= fwd_same_c ? (fwd_q.strb | mem_wstrb) : mem_wstrb;
      for (int i = 0; i < 4; i++) begin
        if (mem_wstrb[i])    fwd_q.data[8*i +: 8] <= mem_wdata[8*i +: 8];
        else if (!fwd_same_c) fwd_q.data[8*i +: 8] <= 8'h00;
      end
    end
  end
`else
  assign fwd_hit_c = 1'b0;
  assign lane_ld_c = mem_rdata;
`endif

  // Request FSM with registered core and bus outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ready     <= 1'b1;
      valid     <= 1'b0;
      err       <= 1'b0;
      data_out  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      tcnt      <= '0;
      lo_q      <= '0;
      width_q   <= W_BYTE;
      ext_q     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (r_ena) begin
            ready   <= 1'b0;
            lo_q    <= addr[1:0];
            width_q <= width_e'(width);
            ext_q   <= ext;
            if (cause_c != ERR_NONE) begin
              state <= S_DONE;
              valid <= 1'b1;
              err   <= 1'b1;
            end else if (fwd_hit_c) begin
              state    <= S_DONE;
              valid    <= 1'b1;
              err      <= 1'b0;
              data_out <= ldata_c;
            end else begin
              state     <= S_REQ;
              err       <= 1'b0;
              mem_req   <= 1'b1;
              mem_we    <= w_ena;
              mem_addr  <= addr[31:2];
              mem_wstrb <= w_ena ? strb_c : 4'b0000;
              mem_wdata <= wdata_c;
              tcnt      <= '0;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            tcnt    <= '0;
            if (mem_we) begin
              state <= S_DONE;
              valid <= 1'b1;
            end else begin
              state <= S_RESP;
            end
          end else if (tmo_c) begin
            mem_req <= 1'b0;
            state   <= S_DONE;
            valid   <= 1'b1;
            err     <= 1'b1;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        S_RESP: begin
          if (mem_rvalid) begin
            state    <= S_DONE;
            valid    <= 1'b1;
            data_out <= ldata_c;
          end else if (tmo_c) begin
            state <= S_DONE;
            valid <= 1'b1;
            err   <= 1'b1;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
